// File: rtl/timer_irq_src.sv
// Memory-mapped interval timer: TH (reload), TL (count) and TCON (EN/IE/STAT)
// registers on the data bus, with a level IRQ that is held low for at least
// two cycles after software clears STAT so the consumer always sees a fresh
// rising edge for every timer event.
//
// Bus handshake: a write takes effect on the posedge where MemWr is high; a
// read is purely combinational from MemRd/addr and shows register state from
// before the current edge. There is no ready/stall: every access completes in
// the cycle it is presented.
module timer_irq_src #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemWr,
    input  logic        MemRd,
    output logic [31:0] rdata,
    output logic        IRQ,
    output logic        tick_out
);

    localparam logic [15:0] PRE_MAX  = 16'(PRESCALE - 1);
    localparam logic [29:0] TH_WORD  = BASE_ADDR[31:2];
    localparam logic [29:0] TL_WORD  = BASE_ADDR[31:2] + 30'd1;
    localparam logic [29:0] TCON_WORD = BASE_ADDR[31:2] + 30'd2;

    logic [31:0] th;
    logic [31:0] tl;
    logic        en;
    logic        ie;
    logic        stat;
    logic [15:0] pre_cnt;
    logic [1:0]  holdoff;

    logic sel_th;
    logic sel_tl;
    logic sel_tcon;
    logic wr_th;
    logic wr_tl;
    logic wr_tcon;
    logic inc;
    logic reload;
    logic set_stat;
    logic stat_next;

    // Address decode (byte offset bits ignored) and the per-edge event strobes.
    always_comb begin
        sel_th    = (addr[31:2] == TH_WORD);
        sel_tl    = (addr[31:2] == TL_WORD);
        sel_tcon  = (addr[31:2] == TCON_WORD);
        wr_th     = MemWr && sel_th;
        wr_tl     = MemWr && sel_tl;
        wr_tcon   = MemWr && sel_tcon;
        inc       = en && (pre_cnt == PRE_MAX);
        // A CPU write to TL swallows the counter update of that edge entirely.
        reload    = inc && (tl == 32'hFFFF_FFFF) && !wr_tl;
        set_stat  = reload && ie;
        // A setting reload beats a clearing write on the same edge.
        stat_next = set_stat || (wr_tcon ? (stat && wdata[2]) : stat);
    end

    // Prescaler: counts enabled cycles, wrapping at PRESCALE-1 to make inc.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= 16'd0;
        end else if (!en || inc) begin
            pre_cnt <= 16'd0;
        end else begin
            pre_cnt <= pre_cnt + 16'd1;
        end
    end

    // TH/TL and the reload pulse; TL reloads from the pre-edge TH value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th       <= 32'd0;
            tl       <= 32'd0;
            tick_out <= 1'b0;
        end else begin
            tick_out <= reload;
            if (wr_th) begin
                th <= wdata;
            end
            if (wr_tl) begin
                tl <= wdata;
            end else if (reload) begin
                tl <= th;
            end else if (inc) begin
                tl <= tl + 32'd1;
            end
        end
    end

    // TCON, the post-clear holdoff and the registered IRQ level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en      <= 1'b0;
            ie      <= 1'b0;
            stat    <= 1'b0;
            holdoff <= 2'd0;
            IRQ     <= 1'b0;
        end else begin
            if (wr_tcon) begin
                en <= wdata[0];
                ie <= wdata[1];
            end
            stat <= stat_next;
            if (stat && !stat_next) begin
                holdoff <= 2'd2;
            end else if (holdoff != 2'd0) begin
                holdoff <= holdoff - 2'd1;
            end
            IRQ <= stat && ie && (holdoff == 2'd0);
        end
    end

    // Combinational read mux; unmapped or idle reads return zero.
    always_comb begin
        rdata = 32'h0;
        if (MemRd) begin
            if (sel_th) begin
                rdata = th;
            end else if (sel_tl) begin
                rdata = tl;
            end else if (sel_tcon) begin
                rdata = {29'd0, stat, ie, en};
            end
        end
    end

endmodule

// File: tb/tb_timer_irq_src.sv
// Bench for timer_irq_src: directed scenarios followed by random bus traffic,
// all checked against an event-level reference model of the timer rules.
module tb_timer_irq_src;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] A_TH = BASE;
    localparam logic [31:0] A_TL = BASE + 32'd4;
    localparam logic [31:0] A_TC = BASE + 32'd8;
    localparam logic [31:0] A_UN = BASE + 32'd12;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        MemWr;
    logic        MemRd;
    logic [31:0] rdata;
    logic        IRQ;
    logic        tick_out;

    logic        reset4;
    logic [31:0] addr4;
    logic [31:0] wdata4;
    logic        MemWr4;
    logic        MemRd4;
    logic [31:0] rdata4;
    logic        irq4;
    logic        tick4;

    int n_vec;
    int n_err;

    // reference model state (PRESCALE = 1 instance)
    logic [31:0] m_th, m_tl;
    logic        m_en, m_ie, m_stat, m_irq, m_tick;
    int          m_hold;

    timer_irq_src #(.BASE_ADDR(BASE), .PRESCALE(1)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .MemWr(MemWr), .MemRd(MemRd), .rdata(rdata), .IRQ(IRQ), .tick_out(tick_out)
    );

    timer_irq_src #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset4), .addr(addr4), .wdata(wdata4),
        .MemWr(MemWr4), .MemRd(MemRd4), .rdata(rdata4), .IRQ(irq4), .tick_out(tick4)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_th = 0; m_tl = 0; m_en = 0; m_ie = 0; m_stat = 0;
        m_irq = 0; m_tick = 0; m_hold = 0;
    endtask

    function automatic logic [31:0] model_rd(input logic rd, input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (!rd) return 32'h0;
        if (w == A_TH) return m_th;
        if (w == A_TL) return m_tl;
        if (w == A_TC) return {29'd0, m_stat, m_ie, m_en};
        return 32'h0;
    endfunction

    // One clock edge of the timer rules, evaluated from pre-edge values.
    task automatic model_edge(input logic wr, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] w;
        logic        wth, wtl, wtc, event_fire;
        logic [31:0] n_tl;
        logic        n_stat, n_irq;
        w   = {a[31:2], 2'b00};
        wth = wr && (w == A_TH);
        wtl = wr && (w == A_TL);
        wtc = wr && (w == A_TC);
        // PRESCALE = 1: every enabled cycle counts
        event_fire = m_en && !wtl && (m_tl == 32'hFFFF_FFFF);
        if (wtl)             n_tl = d;
        else if (event_fire) n_tl = m_th;
        else if (m_en)       n_tl = m_tl + 1;
        else                 n_tl = m_tl;
        n_stat = m_stat;
        if (wtc && !d[2]) n_stat = 1'b0;
        if (event_fire && m_ie) n_stat = 1'b1;
        n_irq  = m_stat && m_ie && (m_hold == 0);
        if (m_stat && !n_stat) m_hold = 2;
        else if (m_hold > 0)   m_hold = m_hold - 1;
        m_tick = event_fire;
        m_irq  = n_irq;
        m_stat = n_stat;
        m_tl   = n_tl;
        if (wth) m_th = d;
        if (wtc) begin
            m_en = d[0];
            m_ie = d[1];
        end
    endtask

    // One bus cycle: entered and left at a negedge.
    task automatic cyc(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
        MemWr = wr; MemRd = rd; addr = a; wdata = d;
        #1;
        chk("rdata", rdata, model_rd(rd, a));
        @(posedge clk);
        model_edge(wr, a, d);
        @(negedge clk);
        chk("irq", {31'd0, IRQ}, {31'd0, m_irq});
        chk("tick", {31'd0, tick_out}, {31'd0, m_tick});
        MemWr = 1'b0; MemRd = 1'b0;
    endtask

    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        MemRd = 1'b1; addr = a;
        #1;
        chk(tag, rdata, exp);
        MemRd = 1'b0;
    endtask

    initial begin
        logic [31:0] rv;
        int          op;
        n_vec = 0; n_err = 0;
        reset = 1'b1; addr = 0; wdata = 0; MemWr = 0; MemRd = 0;
        reset4 = 1'b1; addr4 = 0; wdata4 = 0; MemWr4 = 0; MemRd4 = 0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 1: reset values and unmapped read
        chk("rst_irq", {31'd0, IRQ}, 32'd0);
        chk("rst_tick", {31'd0, tick_out}, 32'd0);
        peek("rst_th", A_TH, 32'h0);
        peek("rst_tl", A_TL, 32'h0);
        peek("rst_tcon", A_TC, 32'h0);
        cyc(1'b1, 1'b0, A_UN, 32'hDEAD_BEEF);
        cyc(1'b0, 1'b1, A_UN, 32'h0);
        peek("unmapped_rd", A_UN, 32'h0);

        // 2: first reload with IE set
        cyc(1'b1, 1'b0, A_TH, 32'hFFFF_FFFC);
        cyc(1'b1, 1'b0, A_TL, 32'hFFFF_FFFE);
        cyc(1'b1, 1'b0, A_TC, 32'h3);
        cyc(1'b0, 1'b1, A_TL, 32'h0);
        peek("tl_top", A_TL, 32'hFFFF_FFFF);
        cyc(1'b0, 1'b1, A_TL, 32'h0);
        chk("tick_first", {31'd0, tick_out}, 32'd1);
        chk("irq_lag", {31'd0, IRQ}, 32'd0);
        peek("tl_reload", A_TL, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b1, A_TC, 32'h0);
        chk("irq_rise", {31'd0, IRQ}, 32'd1);
        repeat (3) cyc(1'b0, 1'b1, A_TL, 32'h0);
        chk("tick_period4", {31'd0, tick_out}, 32'd1);

        // 3: clear STAT just before a reload; holdoff keeps IRQ low 2 cycles
        cyc(1'b1, 1'b0, A_TL, 32'hFFFF_FFFE);
        cyc(1'b1, 1'b0, A_TC, 32'h3);
        chk("irq_clr_edge", {31'd0, IRQ}, 32'd1);
        cyc(1'b0, 1'b1, A_TC, 32'h0);
        chk("irq_low1", {31'd0, IRQ}, 32'd0);
        cyc(1'b0, 1'b1, A_TC, 32'h0);
        chk("irq_low2", {31'd0, IRQ}, 32'd0);
        cyc(1'b0, 1'b1, A_TC, 32'h0);
        chk("irq_second_rise", {31'd0, IRQ}, 32'd1);

        // 4: clear lands on the reload edge -> set wins
        cyc(1'b1, 1'b0, A_TL, 32'hFFFF_FFFF);
        cyc(1'b1, 1'b0, A_TC, 32'h3);
        peek("stat_kept", A_TC, 32'h7);
        cyc(1'b0, 1'b0, A_TC, 32'h0);
        chk("irq_kept", {31'd0, IRQ}, 32'd1);

        // 5: IE=0 across a reload, then TL write on an inc edge
        cyc(1'b1, 1'b0, A_TC, 32'h1);
        cyc(1'b1, 1'b0, A_TL, 32'hFFFF_FFFE);
        cyc(1'b0, 1'b0, A_TL, 32'h0);
        cyc(1'b0, 1'b0, A_TL, 32'h0);
        chk("tick_ie0", {31'd0, tick_out}, 32'd1);
        peek("stat_ie0", A_TC, 32'h1);
        chk("irq_ie0", {31'd0, IRQ}, 32'd0);
        cyc(1'b1, 1'b0, A_TL, 32'd5);
        peek("tl_write_wins", A_TL, 32'd5);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 9);
            rv = 32'hFFFF_FFF0 | $urandom_range(0, 15);
            case (op)
                0: cyc(1'b1, 1'b0, A_TH, rv);
                1: cyc(1'b1, 1'b0, A_TL, rv);
                2: cyc(1'b1, 1'b0, A_TC | $urandom_range(0, 3),
                       {29'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                        1'($urandom_range(0, 4) != 0)});
                3: cyc(1'b1, 1'b0, A_UN | $urandom_range(0, 3), $urandom);
                default: cyc(1'b0, 1'($urandom_range(0, 3) != 0),
                             BASE + 32'($urandom_range(0, 15)), 32'h0);
            endcase
        end

        // 6: PRESCALE = 4 instance, then asynchronous reset mid-count
        reset4 = 1'b0;
        MemWr4 = 1'b1; addr4 = A_TL; wdata4 = 32'h0;
        @(negedge clk);
        addr4 = A_TC; wdata4 = 32'h1;
        @(negedge clk);
        MemWr4 = 1'b0; MemRd4 = 1'b1; addr4 = A_TL;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 3)  chk("p4_tl_3clk", rdata4, 32'd0);
            if (k == 4)  chk("p4_tl_4clk", rdata4, 32'd1);
            if (k == 7)  chk("p4_tl_7clk", rdata4, 32'd1);
            if (k == 8)  chk("p4_tl_8clk", rdata4, 32'd2);
        end
        addr4 = A_TC;
        #1;
        chk("p4_tcon_pre", rdata4, 32'h1);
        addr4 = A_TL;
        #1;
        reset4 = 1'b1;
        #1;
        chk("p4_rst_tl", rdata4, 32'd0);
        chk("p4_rst_irq", {31'd0, irq4}, 32'd0);
        chk("p4_rst_tick", {31'd0, tick4}, 32'd0);
        addr4 = A_TC;
        #1;
        chk("p4_rst_tcon", rdata4, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
